sipo_rx_ctrl: RTL and testbench

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

---
 rtl/sipo_rx_ctrl.sv | 114 +++++++++++
 tb/tb_sipo_rx_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx_ctrl.sv
// Serial-in/parallel-out receiver: frames start on a start pulse, assembles WIDTH
// qualified bits, then holds the word until a valid/ready handshake drains it.
`timescale 1ns/1ps
module sipo_rx_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             si,
  input  logic             si_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic             r_dout_valid, w_dout_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_overrun, w_overrun_nxt;

  always_comb begin
    if (MSB_FIRST) w_shifted = {r_shift[WIDTH-2:0], si};
    else           w_shifted = {si, r_shift[WIDTH-1:1]};
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shift_nxt      = r_shift;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = r_dout_valid;
    w_overrun_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
        end
      end
      S_SHIFT: begin
        // abort outranks a restart, and a restart outranks the data bit
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (start) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
        end else if (si_valid) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_state_nxt      = S_HOLD;
            w_dout_nxt       = w_shifted;
            w_dout_valid_nxt = 1'b1;
          end
        end
      end
      S_HOLD: begin
        w_overrun_nxt = si_valid;
        if (r_dout_valid && dout_ready) begin
          w_state_nxt      = S_IDLE;
          w_dout_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Bench for sipo_rx_ctrl: three instances (W4 MSB-first, W4 LSB-first, W8 MSB-first)
// share stimulus; a frame-level model plus directed vectors check every output.
`timescale 1ns/1ps
module tb_sipo_rx_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, si, si_valid, dout_ready;
  logic [3:0] d4a, d4b;
  logic [7:0] d8;
  logic [2:0] dv, bz, ov;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sipo_rx_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .si(si), .si_valid(si_valid),
    .dout(d4a), .dout_valid(dv[0]), .dout_ready(dout_ready), .busy(bz[0]), .overrun(ov[0]));
  sipo_rx_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .si(si), .si_valid(si_valid),
    .dout(d4b), .dout_valid(dv[1]), .dout_ready(dout_ready), .busy(bz[1]), .overrun(ov[1]));
  sipo_rx_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .si(si), .si_valid(si_valid),
    .dout(d8), .dout_valid(dv[2]), .dout_ready(dout_ready), .busy(bz[2]), .overrun(ov[2]));

  // Frame-level reference: a list of received bits, packed into a word once complete.
  int          mw [3] = '{4, 4, 8};
  bit          mm [3] = '{1'b1, 1'b0, 1'b1};
  bit          m_armed [3];
  bit          m_hold  [3];
  bit          m_dv    [3];
  bit          m_ovr   [3];
  int          m_cnt   [3];
  bit          m_bits  [3][32];
  logic [31:0] m_dout  [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] assemble(input int k);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < mw[k]; i++) begin
      if (mm[k]) w[mw[k]-1-i] = m_bits[k][i];
      else       w[i]         = m_bits[k][i];
    end
    return w;
  endfunction

  function automatic logic [31:0] act_dout(input int k);
    case (k)
      0:       return {28'b0, d4a};
      1:       return {28'b0, d4b};
      default: return {24'b0, d8};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_armed[k] = 1'b0;
      m_hold[k]  = 1'b0;
      m_dv[k]    = 1'b0;
      m_ovr[k]   = 1'b0;
      m_cnt[k]   = 0;
      m_dout[k]  = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_ovr[k] = m_hold[k] && si_valid;
      if (m_hold[k]) begin
        if (dout_ready) begin
          m_hold[k] = 1'b0;
          m_dv[k]   = 1'b0;
        end
      end else if (m_armed[k]) begin
        if (abort) begin
          m_armed[k] = 1'b0;
          m_cnt[k]   = 0;
        end else if (start) begin
          m_cnt[k] = 0;
        end else if (si_valid) begin
          m_bits[k][m_cnt[k]] = si;
          m_cnt[k]++;
          if (m_cnt[k] == mw[k]) begin
            m_dout[k]  = assemble(k);
            m_dv[k]    = 1'b1;
            m_hold[k]  = 1'b1;
            m_armed[k] = 1'b0;
            m_cnt[k]   = 0;
          end
        end
      end else if (start) begin
        m_armed[k] = 1'b1;
        m_cnt[k]   = 0;
      end
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mdl%0d.dout", k), act_dout(k), m_dout[k]);
      chk($sformatf("mdl%0d.dout_valid", k), {31'b0, dv[k]}, {31'b0, m_dv[k]});
      chk($sformatf("mdl%0d.busy", k), {31'b0, bz[k]}, {31'b0, (m_armed[k] || m_hold[k])});
      chk($sformatf("mdl%0d.overrun", k), {31'b0, ov[k]}, {31'b0, m_ovr[k]});
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic d, input logic v, input logic r);
    start = s; abort = a; si = d; si_valid = v; dout_ready = r;
  endtask

  // Inputs change 1ns after a rising edge; the model consumes them before the next edge.
  task automatic tick();
    if (rst) model_step();
    else     model_reset();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic send_bit(input logic b);
    drive(1'b0, 1'b0, b, 1'b1, 1'b0);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dout4m"}, {28'b0, d4a}, 32'h0);
    chk({tag, ".dout4l"}, {28'b0, d4b}, 32'h0);
    chk({tag, ".dout8"},  {24'b0, d8},  32'h0);
    chk({tag, ".valid"},  {29'b0, dv},  32'h0);
    chk({tag, ".busy"},   {29'b0, bz},  32'h0);
    chk({tag, ".ovr"},    {29'b0, ov},  32'h0);
  endtask

  typedef struct {
    logic st, ab, sd, sv, rd;
    logic [3:0] ed;
    logic ev, eb, eo;
  } vec_t;

  vec_t tv [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp8;
    logic       bv;
    int         gap;

    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,    1'b0, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,    1'b0, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0,    1'b0, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0,    1'b0, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,    1'b0, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;

    // W4 MSB-first walk: ignored bits in IDLE, gap, HOLD overrun, handshake
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].st, tv[i].ab, tv[i].sd, tv[i].sv, tv[i].rd);
      tick();
      chk($sformatf("vec%0d.dout", i),  {28'b0, d4a},   {28'b0, tv[i].ed});
      chk($sformatf("vec%0d.valid", i), {31'b0, dv[0]}, {31'b0, tv[i].ev});
      chk($sformatf("vec%0d.busy", i),  {31'b0, bz[0]}, {31'b0, tv[i].eb});
      chk($sformatf("vec%0d.ovr", i),   {31'b0, ov[0]}, {31'b0, tv[i].eo});
    end

    // LSB-first word held across 5 not-ready cycles
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("lsb.dout", {28'b0, d4b}, 32'hD);
    chk("lsb.valid", {31'b0, dv[1]}, 32'h1);
    chk("lsb.busy", {31'b0, bz[1]}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      chk($sformatf("lsb.stall%0d.dout", i), {28'b0, d4b}, 32'hD);
      chk($sformatf("lsb.stall%0d.valid", i), {31'b0, dv[1]}, 32'h1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk("lsb.drain.valid", {31'b0, dv[1]}, 32'h0);
    chk("lsb.drain.busy", {31'b0, bz[1]}, 32'h0);
    chk("lsb.drain.dout", {28'b0, d4b}, 32'hD);

    // W8 with random gaps between qualified bits
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    exp8 = '0;
    for (int b = 0; b < 8; b++) begin
      gap = int'($urandom_range(0, 3));
      for (int j = 0; j < gap; j++) begin
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0); tick();
        chk("w8.gap.valid", {31'b0, dv[2]}, 32'h0);
      end
      bv = 1'($urandom_range(0, 1));
      exp8[7-b] = bv;
      send_bit(bv);
      if (b < 7) chk("w8.early.valid", {31'b0, dv[2]}, 32'h0);
    end
    chk("w8.valid", {31'b0, dv[2]}, 32'h1);
    chk("w8.dout", {24'b0, d8}, {24'b0, exp8});
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk("w8.drain.valid", {31'b0, dv[2]}, 32'h0);

    // Overrun pulses in HOLD, then a clean second frame
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("ovr.dout", {28'b0, d4a}, 32'h6);
    for (int p = 0; p < 2; p++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
      chk($sformatf("ovr.pulse%0d", p), {31'b0, ov[0]}, 32'h1);
      chk($sformatf("ovr.pulse%0d.dout", p), {28'b0, d4a}, 32'h6);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      chk($sformatf("ovr.gap%0d", p), {31'b0, ov[0]}, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk("ovr.drain.valid", {31'b0, dv[0]}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("ovr.next.dout", {28'b0, d4a}, 32'hC);
    chk("ovr.next.valid", {31'b0, dv[0]}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();

    // Abort beats start; restart discards a partial word
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    send_bit(1'b1); send_bit(1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    chk("abort.busy", {29'b0, bz}, 32'h0);
    chk("abort.valid", {29'b0, dv}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    send_bit(1'b1); send_bit(1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("restart.dout4m", {28'b0, d4a}, 32'h4);
    chk("restart.dout4l", {28'b0, d4b}, 32'h2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();

    // Asynchronous reset mid-SHIFT, then bits without start
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    send_bit(1'b1); send_bit(1'b0);
    #2 rst = 1'b0;
    #1 chk_all_zero("arst.shift");
    model_reset();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      chk("arst.nostart.valid", {29'b0, dv}, 32'h0);
    end

    // Asynchronous reset mid-HOLD while overrun is high
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1);
    chk("arst.pre.ovr", {31'b0, ov[0]}, 32'h1);
    #2 rst = 1'b0;
    #1 chk_all_zero("arst.hold");
    model_reset();
    tick();
    rst = 1'b1;

    // Random traffic against the frame-level model
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
